// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed four-digit seven-segment driver. It takes four BCD digits
// and copies them into a snapshot once per scan frame, so a frame never shows
// a mix of old and new digits. It then lights one digit at a time through an
// active-low anode. The segment and decimal-point outputs are also active low
// and always match the lit digit.
//
// Parameters:
//   SCAN_DIV  board-clock cycles each digit stays lit (2 .. 2^20)
//
// Ports:
//   clk      in   board clock (single clock domain)
//   rst_n    in   asynchronous active-low reset
//   digits   in   [15:0] four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_mask  in   [3:0]  bit i lights digit i's decimal point
//   disp_en  in   1 = display on, 0 = all anodes off (scan keeps running)
//   an       out  [3:0]  anode enables, active low, one-hot-low when on
//   seg      out  [6:0]  segments {g,f,e,d,c,b,a}, active low
//   dp       out  decimal point, active low
//   frame    out  one-cycle pulse, asserted when digit 0 of a new
//                 snapshot becomes visible
//
// Build option:
//   SEG_LZ_BLANK_EN  when defined, leading zeros in digits 3..1 are blanked.
//                    Digit 0 is never blanked.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        disp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned          DIV_W   = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]     DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]           SEG_OFF = 7'h7F;
    localparam logic [6:0]           SEG_DASH = 7'h3F;

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [15:0]      snap;
    logic [3:0]       snap_dp;
    logic             wrap_q;     // snapshot was loaded on the previous edge

    logic             tick;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic             lz_blank;

    // BCD to active-low segments. Codes 10..15 are not valid BCD and show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_DASH;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
        lz_blank = 1'b0;
        tick     = (div == DIV_MAX);
        nibble   = snap[{idx, 2'b00} +: 4];
        seg_dec  = bcd_to_seg(nibble);
`ifdef SEG_LZ_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero.
        case (idx)
            2'd3:    lz_blank = (snap[15:12] == 4'h0);
            2'd2:    lz_blank = (snap[15:8]  == 8'h00);
            2'd1:    lz_blank = (snap[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            idx     <= 2'd0;
            snap    <= 16'h0000;
            snap_dp <= 4'h0;
            wrap_q  <= 1'b0;
            an      <= 4'hF;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
            frame   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            div    <= tick ? '0 : div + DIV_W'(1);
            wrap_q <= 1'b0;
            if (tick) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    snap    <= digits;
                    snap_dp <= dp_mask;
                    wrap_q  <= 1'b1;
                end
            end

            // The outputs show the idx/snap state from before this edge.
            // frame is delayed by wrap_q, so it lines up with the first
            // cycle in which the new snapshot's digit 0 is lit.
            frame <= wrap_q;
            if (disp_en) begin
                an  <= ~(4'b0001 << idx);
                seg <= lz_blank ? SEG_OFF : seg_dec;
                dp  <= ~snap_dp[idx];
            end else begin
                an  <= 4'hF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Testbench for seg7_scan_driver with SCAN_DIV = 4. A behavioural model
// counts clock edges since reset release and computes the expected outputs
// for each cycle from that count. A compare process checks the DUT against
// the model on every falling edge. Directed checks then fix hand-computed
// values at selected points in each frame.
// Define SEG_LZ_BLANK_EN for both the bench and the RTL to exercise
// leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        disp_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digits  (digits),
        .dp_mask (dp_mask),
        .disp_en (disp_en),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [3:0] e_an_v, input logic [6:0] e_seg_v,
                       input logic e_dp_v);
        check({name, "_an"},  {12'd0, an},  {12'd0, e_an_v});
        check({name, "_seg"}, {9'd0, seg},  {9'd0, e_seg_v});
        check({name, "_dp"},  {15'd0, dp},  {15'd0, e_dp_v});
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    int          n_edge = 0;        // rising edges since reset release
    int          m_slot = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0]  m_sdp  = 4'h0;
    logic [3:0]  e_an   = 4'hF;
    logic [6:0]  e_seg  = 7'h7F;
    logic        e_dp   = 1'b1;
    logic        e_frame = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge = 0; m_snap = 16'h0; m_sdp = 4'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
        end else begin
            n_edge++;
            // The output after edge n shows the slot that was active
            // during cycle n-1. Each slot lasts SD cycles and a frame
            // lasts 4*SD cycles.
            m_slot  = ((n_edge - 1) / SD) % 4;
            e_frame = (n_edge > 1) && ((n_edge - 1) % (4 * SD) == 0);
            if (disp_en) begin
                e_an  = ~(4'(1 << m_slot));
                e_seg = seg_of(4'(m_snap >> (4 * m_slot)));
                e_dp  = ~m_sdp[m_slot];
`ifdef SEG_LZ_BLANK_EN
                if (m_slot > 0 && (m_snap >> (4 * m_slot)) == 0) e_seg = 7'h7F;
`endif
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            // The snapshot reloads on every edge that ends a full frame.
            if (n_edge % (4 * SD) == 0) begin
                m_snap = digits;
                m_sdp  = dp_mask;
            end
        end
    end

    always @(negedge clk) begin
        check("model_an",    {12'd0, an},    {12'd0, e_an});
        check("model_seg",   {9'd0, seg},    {9'd0, e_seg});
        check("model_dp",    {15'd0, dp},    {15'd0, e_dp});
        check("model_frame", {15'd0, frame}, {15'd0, e_frame});
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            seen = (frame === 1'b1);
        end
        check({tag, "_frame_seen"}, {15'd0, seen}, 16'd1);
    endtask

    task automatic next_slot();
        repeat (SD) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; digits = 16'h0; dp_mask = 4'h0; disp_en = 1'b1;
        repeat (3) @(negedge clk);

        // Held in reset: display off.
        pin("rst_hold", 4'hF, 7'h7F, 1'b1);
        rst_n = 1'b1;
        // Digit 0 of the all-zero reset snapshot stays lit for SD cycles.
        // The first tick then moves the scan to digit 1.
        repeat (SD) begin
            @(negedge clk);
            pin("t1_slot0", 4'hE, 7'h40, 1'b1);
        end
        @(negedge clk);
        pin("t1_first_tick", 4'hD, 7'h40, 1'b1);

        // Scan order: 1234, decimal point on digit 2.
        digits = 16'h1234; dp_mask = 4'b0100;
        wait_frame("t2");
        pin("t2_d0", 4'hE, 7'h19, 1'b1);
        next_slot(); pin("t2_d1", 4'hD, 7'h30, 1'b1);
        next_slot(); pin("t2_d2", 4'hB, 7'h24, 1'b0);
        next_slot(); pin("t2_d3", 4'h7, 7'h79, 1'b1);

        // Reset asserted mid-frame must blank the display without a clock edge.
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        pin("async_rst", 4'hF, 7'h7F, 1'b1);
        check("async_rst_frame", {15'd0, frame}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pin("post_rst_d0", 4'hE, 7'h40, 1'b1);

        // Tear-free snapshot: change the digits while digit 1 is lit.
        digits = 16'h5678; dp_mask = 4'b0001;
        wait_frame("t3a");
        pin("t3_d0", 4'hE, 7'h00, 1'b0);
        next_slot(); pin("t3_d1", 4'hD, 7'h78, 1'b1);
        digits = 16'h9999;
        next_slot(); pin("t3_d2_old", 4'hB, 7'h02, 1'b1);
        next_slot(); pin("t3_d3_old", 4'h7, 7'h12, 1'b1);
        wait_frame("t3b");
        pin("t3_new_d0", 4'hE, 7'h10, 1'b0);

        // Invalid BCD nibbles show a dash.
        digits = 16'hA0F9; dp_mask = 4'h0;
        wait_frame("t4");
        pin("t4_d0", 4'hE, 7'h10, 1'b1);
        next_slot(); pin("t4_d1", 4'hD, 7'h3F, 1'b1);
        next_slot(); pin("t4_d2", 4'hB, 7'h40, 1'b1);
        next_slot(); pin("t4_d3", 4'h7, 7'h3F, 1'b1);

        // Disable for 6 cycles mid-frame. The scan must not slip a slot.
        wait_frame("t5");
        repeat (2) @(negedge clk);
        disp_en = 1'b0;
        @(negedge clk);
        pin("t5_blank", 4'hF, 7'h7F, 1'b1);
        repeat (5) @(negedge clk);
        disp_en = 1'b1;
        @(negedge clk);
        pin("t5_resume", 4'hB, 7'h40, 1'b1);

        // Leading zeros.
        digits = 16'h0050;
        wait_frame("t6");
        pin("t6_d0", 4'hE, 7'h40, 1'b1);
        next_slot(); pin("t6_d1", 4'hD, 7'h12, 1'b1);
`ifdef SEG_LZ_BLANK_EN
        next_slot(); pin("t6_d2", 4'hB, 7'h7F, 1'b1);
        next_slot(); pin("t6_d3", 4'h7, 7'h7F, 1'b1);
`else
        next_slot(); pin("t6_d2", 4'hB, 7'h40, 1'b1);
        next_slot(); pin("t6_d3", 4'h7, 7'h40, 1'b1);
`endif
        digits = 16'h0000;
        wait_frame("t6z");
        pin("t6z_d0", 4'hE, 7'h40, 1'b1);
`ifdef SEG_LZ_BLANK_EN
        next_slot(); pin("t6z_d1", 4'hD, 7'h7F, 1'b1);
`else
        next_slot(); pin("t6z_d1", 4'hD, 7'h40, 1'b1);
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
